// File: rtl/dtree_pkg.sv
// Shared types for the decision-tree walker: FSM states, node field layout and node unpacking.
// Node words are unpacked into a maximum-width struct so that one type serves every parameter set.
package dtree_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EVAL  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int MAX_FEAT_W = 8;
    localparam int MAX_ATTR_W = 32;
    localparam int MAX_ADDR_W = 16;
    localparam int MAX_NODE_W = MAX_FEAT_W + MAX_ATTR_W + 2 * (1 + MAX_ADDR_W);

    typedef struct packed {
        logic [MAX_FEAT_W-1:0] feat;
        logic [MAX_ATTR_W-1:0] thresh;
        logic                  left_leaf;
        logic [MAX_ADDR_W-1:0] left_ptr;
        logic                  right_leaf;
        logic [MAX_ADDR_W-1:0] right_ptr;
    } node_t;

    // Field offsets within a node word, LSB first: right_ptr, right_leaf, left_ptr, left_leaf, thresh, feat.
    function automatic int off_right_leaf(input int addr_w);
        return addr_w;
    endfunction

    function automatic int off_left_ptr(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int off_left_leaf(input int addr_w);
        return 2 * addr_w + 1;
    endfunction

    function automatic int off_thresh(input int addr_w);
        return 2 * addr_w + 2;
    endfunction

    function automatic int off_feat(input int attr_w, input int addr_w);
        return 2 * addr_w + 2 + attr_w;
    endfunction

    function automatic node_t unpack_node(
        input logic [MAX_NODE_W-1:0] word,
        input int                    feat_w,
        input int                    attr_w,
        input int                    addr_w
    );
        node_t n;
        n = '0;
        for (int i = 0; i < MAX_ADDR_W; i++) begin
            if (i < addr_w) begin
                n.right_ptr[i] = word[i];
                n.left_ptr[i]  = word[off_left_ptr(addr_w) + i];
            end
        end
        n.right_leaf = word[off_right_leaf(addr_w)];
        n.left_leaf  = word[off_left_leaf(addr_w)];
        for (int i = 0; i < MAX_ATTR_W; i++) begin
            if (i < attr_w) begin
                n.thresh[i] = word[off_thresh(addr_w) + i];
            end
        end
        for (int i = 0; i < MAX_FEAT_W; i++) begin
            if (i < feat_w) begin
                n.feat[i] = word[off_feat(attr_w, addr_w) + i];
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/dtree_node_ram.sv
// Node table storage: simple dual-port RAM, one write and one registered read port, no reset.
// Out-of-range write addresses are filtered by the caller.
module dtree_node_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 30
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dtree_walker.sv
// Decision-tree inference engine: walks the node table from the root to a leaf for one sample
// and reports class, hop count and an error flag over a valid/ready handshake.
module dtree_walker
    import dtree_pkg::*;
#(
    parameter int ATTR_W   = 10,
    parameter int N_ATTR   = 4,
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 256,
    parameter int CLASS_W  = 8,
    parameter int MAX_HOPS = 16,
    localparam int FEAT_W  = (N_ATTR > 1) ? $clog2(N_ATTR) : 1,
    localparam int NODE_W  = FEAT_W + ATTR_W + 2 * (1 + ADDR_W),
    localparam int HOP_W   = $clog2(MAX_HOPS + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_cfg_we,
    input  logic [ADDR_W-1:0]        i_cfg_addr,
    input  logic [NODE_W-1:0]        i_cfg_data,
    output logic                     o_cfg_ready,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [N_ATTR*ATTR_W-1:0] i_in_attr,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [CLASS_W-1:0]       o_out_class,
    output logic [HOP_W-1:0]         o_out_hops,
    output logic                     o_out_err
);

    generate
        if (CLASS_W > ADDR_W) begin : g_bad_class_w
            $error("dtree_walker: CLASS_W must not exceed ADDR_W");
        end
        if (DEPTH > (1 << ADDR_W)) begin : g_bad_depth
            $error("dtree_walker: DEPTH must not exceed 2**ADDR_W");
        end
        if (NODE_W > MAX_NODE_W || ATTR_W > MAX_ATTR_W || ADDR_W > MAX_ADDR_W) begin : g_bad_node_w
            $error("dtree_walker: node fields exceed dtree_pkg maximum widths");
        end
    endgenerate

    localparam logic [HOP_W-1:0] HOPS_LIMIT = HOP_W'(MAX_HOPS);

    state_t              r_state;
    logic                r_idle;
    logic [ADDR_W-1:0]   r_addr;
    logic [HOP_W-1:0]    r_hops;
    logic [ATTR_W-1:0]   r_attr [N_ATTR];
    logic                r_out_valid;
    logic [CLASS_W-1:0]  r_out_class;
    logic [HOP_W-1:0]    r_out_hops;
    logic                r_out_err;

    logic [ATTR_W-1:0]   w_in_attr [N_ATTR];
    logic                w_cfg_wr;
    logic [NODE_W-1:0]   w_rdata;
    node_t               w_node;
    logic [ATTR_W-1:0]   w_attr_sel;
    logic                w_feat_bad;
    logic                w_go_left;
    logic                w_branch_leaf;
    logic [MAX_ADDR_W-1:0] w_branch_ptr;
    logic [HOP_W-1:0]    w_hops_inc;
    logic                w_unused_node_bits;

    generate
        for (genvar gi = 0; gi < N_ATTR; gi++) begin : g_attr_split
            assign w_in_attr[gi] = i_in_attr[gi*ATTR_W +: ATTR_W];
        end
    endgenerate

    // Writes land only while idle, so a same-cycle sample sees the freshly written word on its fetch.
    assign w_cfg_wr = i_cfg_we && (r_state == ST_IDLE) && (32'(i_cfg_addr) < DEPTH);

    dtree_node_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (NODE_W)
    ) u_node_ram (
        .i_clk   (i_clk),
        .i_we    (w_cfg_wr),
        .i_waddr (i_cfg_addr),
        .i_wdata (i_cfg_data),
        .i_re    (r_state == ST_FETCH),
        .i_raddr (r_addr),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_node     = unpack_node(MAX_NODE_W'(w_rdata), FEAT_W, ATTR_W, ADDR_W);
        w_feat_bad = (32'(w_node.feat) >= N_ATTR);
        w_attr_sel = '0;
        for (int k = 0; k < N_ATTR; k++) begin
            if (32'(w_node.feat) == k) begin
                w_attr_sel = r_attr[k];
            end
        end
        w_go_left     = (32'(w_attr_sel) <= w_node.thresh);
        w_branch_leaf = w_go_left ? w_node.left_leaf : w_node.right_leaf;
        w_branch_ptr  = w_go_left ? w_node.left_ptr  : w_node.right_ptr;
        w_hops_inc    = r_hops + HOP_W'(1);
    end

    assign w_unused_node_bits = ^w_node;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_idle      <= 1'b1;
            r_addr      <= '0;
            r_hops      <= '0;
            r_out_valid <= 1'b0;
            r_out_class <= '0;
            r_out_hops  <= '0;
            r_out_err   <= 1'b0;
            for (int k = 0; k < N_ATTR; k++) begin
                r_attr[k] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_in_valid) begin
                        for (int k = 0; k < N_ATTR; k++) begin
                            r_attr[k] <= w_in_attr[k];
                        end
                        r_addr  <= '0;
                        r_hops  <= '0;
                        r_idle  <= 1'b0;
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_EVAL;
                end
                ST_EVAL: begin
                    r_hops <= w_hops_inc;
                    if (w_feat_bad || w_branch_leaf || (w_hops_inc == HOPS_LIMIT)) begin
                        r_out_valid <= 1'b1;
                        r_out_hops  <= w_hops_inc;
                        r_state     <= ST_DONE;
                        if (!w_feat_bad && w_branch_leaf) begin
                            r_out_class <= w_branch_ptr[CLASS_W-1:0];
                            r_out_err   <= 1'b0;
                        end else begin
                            r_out_class <= '0;
                            r_out_err   <= 1'b1;
                        end
                    end else begin
                        r_addr  <= w_branch_ptr[ADDR_W-1:0];
                        r_state <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_idle      <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_idle  <= 1'b1;
                end
            endcase
        end
    end

    assign o_cfg_ready = r_idle;
    assign o_in_ready  = r_idle;
    assign o_out_valid = r_out_valid;
    assign o_out_class = r_out_class;
    assign o_out_hops  = r_out_hops;
    assign o_out_err   = r_out_err;

endmodule
